// File: rtl/mem_bus_controller.sv
// mem_bus_controller: terminates the core's shared address/data bus and turns each request into one synchronous SRAM access.
// Latency: in-range write ready at cycle WAIT_STATES+2, in-range read at WAIT_STATES+READ_LATENCY+2, out-of-range at cycle 1.
// Backpressure: cpu_mem_ready stays low while a request is in flight; the core holds its request level until ready.
//
// Ports:
//   clk, rst                         clock (rising edge), asynchronous active-high reset
//   cpu_addr, cpu_data               byte address from the core; shared bidirectional data bus
//   cpu_mem_read, cpu_mem_write      level request strobes from the core
//   cpu_mem_ready                    core advance enable
//   sram_en/we/addr/wdata/rdata      synchronous single-port SRAM interface
//   bus_error, error_addr            sticky error flag and address of the first offending request
//   access_count                     number of completed requests (wraps)
module mem_bus_controller #(
    parameter int ADDR_BITS    = 16,
    parameter int WAIT_STATES  = 0,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          cpu_addr,
    inout  wire  [31:0]          cpu_data,
    input  logic                 cpu_mem_read,
    input  logic                 cpu_mem_write,
    output logic                 cpu_mem_ready,
    output logic                 sram_en,
    output logic                 sram_we,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic [31:0]          sram_wdata,
    input  logic [31:0]          sram_rdata,
    output logic                 bus_error,
    output logic [31:0]          error_addr,
    output logic [31:0]          access_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RDWAIT,
        S_DONE
    } state_t;

    // One past the last valid byte address; 33 bits so ADDR_BITS=30 still works.
    localparam logic [32:0] BYTE_LIMIT = 33'd1 << (ADDR_BITS + 2);
    localparam logic [3:0]  WAIT_LAST  = 4'(WAIT_STATES - 1);
    localparam logic [3:0]  RD_LAST    = 4'(READ_LATENCY - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [3:0]             cnt;
    logic                   op_write;
    logic [ADDR_BITS-1:0]   word_addr;
    logic [31:0]            wdata_lat;
    logic [31:0]            rbuf;
    logic                   drive_data;

    logic                   req;
    logic                   out_of_range;
    logic                   cur_write;
    logic [ADDR_BITS-1:0]   cur_addr;
    logic [31:0]            cur_wdata;

    assign req          = cpu_mem_read | cpu_mem_write;
    assign out_of_range = ({1'b0, cpu_addr} >= BYTE_LIMIT);

    // In IDLE the request is taken straight from the bus (so a zero-wait
    // access can strobe the SRAM on the next cycle); afterwards only the
    // latched copy is used, so later bus changes are ignored.
    // A simultaneous read+write resolves to a write because cpu_mem_write wins.
    assign cur_write = (state == S_IDLE) ? cpu_mem_write : op_write;
    assign cur_addr  = (state == S_IDLE) ? cpu_addr[ADDR_BITS+1:2] : word_addr;
    assign cur_wdata = (state == S_IDLE) ? cpu_data : wdata_lat;

    // Read data only goes on the bus while the core is still asking for it,
    // and never while the core could be driving write data.
    assign cpu_data = drive_data ? rbuf : {32{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cpu_mem_ready = 1'b0;
        drive_data    = 1'b0;
        case (state)
            S_IDLE: begin
                cpu_mem_ready = !req;
                if (req) begin
                    if (out_of_range) begin
                        state_nxt = S_DONE;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt = S_WAIT;
                    end else begin
                        state_nxt = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_nxt = op_write ? S_DONE : S_RDWAIT;
            end
            S_RDWAIT: begin
                if (cnt == RD_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                cpu_mem_ready = 1'b1;
                drive_data    = !op_write && cpu_mem_read && !cpu_mem_write;
                state_nxt     = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (rst) begin
            cpu_mem_ready = 1'b0;
            drive_data    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            op_write     <= 1'b0;
            word_addr    <= '0;
            wdata_lat    <= '0;
            rbuf         <= '0;
            sram_en      <= 1'b0;
            sram_we      <= 1'b0;
            sram_addr    <= '0;
            sram_wdata   <= '0;
            bus_error    <= 1'b0;
            error_addr   <= '0;
            access_count <= '0;
        end else begin
            // Strobe is registered so it is high for exactly the ACCESS cycle.
            sram_en <= (state_nxt == S_ACCESS);
            sram_we <= (state_nxt == S_ACCESS) && cur_write;
            if (state_nxt == S_ACCESS) begin
                sram_addr <= cur_addr;
                if (cur_write) begin
                    sram_wdata <= cur_wdata;
                end
            end

            // Cycle counter for WAIT and RDWAIT; restarts on every state change.
            cnt <= (state_nxt == state) ? cnt + 4'd1 : 4'd0;

            if (state == S_IDLE && req) begin
                op_write  <= cpu_mem_write;
                word_addr <= cpu_addr[ADDR_BITS+1:2];
                wdata_lat <= cpu_data;
                rbuf      <= '0;    // out-of-range reads return zero
                if (out_of_range || (cpu_mem_read && cpu_mem_write)) begin
                    bus_error <= 1'b1;
                    if (!bus_error) begin
                        error_addr <= cpu_addr;
                    end
                end
            end

            if (state == S_RDWAIT && state_nxt == S_DONE) begin
                rbuf <= sram_rdata;
            end

            if (state == S_DONE) begin
                access_count <= access_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_controller.sv
module tb_mem_bus_controller;

    logic        clk;
    logic        rst;

    // Instance A: default parameters (ADDR_BITS=16, no wait states, latency 1)
    logic [31:0] a_addr;
    logic        a_read;
    logic        a_write;
    logic        a_rdy;
    logic        a_en;
    logic        a_we;
    logic [15:0] a_saddr;
    logic [31:0] a_wd;
    logic [31:0] a_rd;
    logic        a_err;
    logic [31:0] a_eaddr;
    logic [31:0] a_cnt;
    wire  [31:0] a_data;
    logic        a_drv;
    logic [31:0] a_drv_val;
    assign a_data = a_drv ? a_drv_val : {32{1'bz}};
    wire a_hiz = (a_data === 32'hzzzz_zzzz);

    // Instance B: WAIT_STATES=2, READ_LATENCY=3
    logic [31:0] b_addr;
    logic        b_read;
    logic        b_write;
    logic        b_rdy;
    logic        b_en;
    logic        b_we;
    logic [15:0] b_saddr;
    logic [31:0] b_wd;
    logic [31:0] b_rd;
    logic        b_err;
    logic [31:0] b_eaddr;
    logic [31:0] b_cnt;
    wire  [31:0] b_data;

    logic [31:0] mem0 [0:255];
    logic [31:0] mem1 [0:255];
    logic [31:0] b_p1;
    logic [31:0] b_p2;
    int          a_strobes = 0;
    int          b_strobes = 0;
    int          n_checks  = 0;
    int          n_fail    = 0;
    int          s_snap;

    mem_bus_controller u_a (
        .clk(clk), .rst(rst), .cpu_addr(a_addr), .cpu_data(a_data),
        .cpu_mem_read(a_read), .cpu_mem_write(a_write), .cpu_mem_ready(a_rdy),
        .sram_en(a_en), .sram_we(a_we), .sram_addr(a_saddr), .sram_wdata(a_wd),
        .sram_rdata(a_rd), .bus_error(a_err), .error_addr(a_eaddr), .access_count(a_cnt)
    );

    mem_bus_controller #(.ADDR_BITS(16), .WAIT_STATES(2), .READ_LATENCY(3)) u_b (
        .clk(clk), .rst(rst), .cpu_addr(b_addr), .cpu_data(b_data),
        .cpu_mem_read(b_read), .cpu_mem_write(b_write), .cpu_mem_ready(b_rdy),
        .sram_en(b_en), .sram_we(b_we), .sram_addr(b_saddr), .sram_wdata(b_wd),
        .sram_rdata(b_rd), .bus_error(b_err), .error_addr(b_eaddr), .access_count(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models: read data is valid only in the cycle exactly READ_LATENCY
    // after the strobe, garbage otherwise, so a mistimed capture shows up.
    always @(posedge clk) begin
        if (rst) begin
            mem0[0] <= 32'h0800_0000;
        end else if (a_en && a_we) begin
            mem0[a_saddr[7:0]] <= a_wd;
        end
        a_rd <= (a_en && !a_we) ? mem0[a_saddr[7:0]] : 32'hDEAD_BEEF;
        if (a_en) a_strobes <= a_strobes + 1;
    end

    always @(posedge clk) begin
        if (rst) begin
            mem1[4] <= 32'hCAFE_0004;
        end else if (b_en && b_we) begin
            mem1[b_saddr[7:0]] <= b_wd;
        end
        b_p1 <= (b_en && !b_we) ? mem1[b_saddr[7:0]] : 32'hDEAD_BEEF;
        b_p2 <= b_p1;
        b_rd <= b_p2;
        if (b_en) b_strobes <= b_strobes + 1;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_addr = '0; a_read = 1'b0; a_write = 1'b0; a_drv = 1'b0; a_drv_val = '0;
        b_addr = '0; b_read = 1'b0; b_write = 1'b0;

        // Reset state
        next_cycle();
        #2;
        chk1("rst_ready", a_rdy, 1'b0);
        chk1("rst_en", a_en, 1'b0);
        chk1("rst_hiz", a_hiz, 1'b1);
        next_cycle();
        rst = 1'b0;

        // Idle, no request for 5 cycles
        repeat (5) next_cycle();
        #2;
        chk1("idle_ready", a_rdy, 1'b1);
        chk1("idle_en", a_en, 1'b0);
        chk1("idle_hiz", a_hiz, 1'b1);
        chk("idle_count", a_cnt, 32'd0);
        chk1("idle_err", a_err, 1'b0);

        // Write 0xA5A51234 to 0x100
        next_cycle();
        a_write = 1'b1; a_addr = 32'h0000_0100; a_drv = 1'b1; a_drv_val = 32'hA5A5_1234;
        #2;
        chk1("wr_c0_ready", a_rdy, 1'b0);
        next_cycle();
        a_drv = 1'b0; a_addr = 32'h0000_0200;   // bus changes must be ignored
        #2;
        chk1("wr_c1_en", a_en, 1'b1);
        chk1("wr_c1_we", a_we, 1'b1);
        chk("wr_c1_saddr", {16'h0, a_saddr}, 32'h0000_0040);
        chk("wr_c1_wdata", a_wd, 32'hA5A5_1234);
        chk1("wr_c1_ready", a_rdy, 1'b0);
        next_cycle();
        #2;
        chk1("wr_c2_ready", a_rdy, 1'b1);
        chk1("wr_c2_en", a_en, 1'b0);
        chk1("wr_c2_hiz", a_hiz, 1'b1);
        next_cycle();
        a_write = 1'b0;
        #2;
        chk("wr_count", a_cnt, 32'd1);
        chk("wr_mem", mem0[8'h40], 32'hA5A5_1234);

        // Read 0x100
        next_cycle();
        a_read = 1'b1; a_addr = 32'h0000_0100;
        #2;
        chk1("rd_c0_ready", a_rdy, 1'b0);
        next_cycle();
        #2;
        chk1("rd_c1_en", a_en, 1'b1);
        chk1("rd_c1_we", a_we, 1'b0);
        chk("rd_c1_saddr", {16'h0, a_saddr}, 32'h0000_0040);
        next_cycle();
        #2;
        chk1("rd_c2_ready", a_rdy, 1'b0);
        next_cycle();
        #2;
        chk1("rd_c3_ready", a_rdy, 1'b1);
        chk("rd_c3_data", a_data, 32'hA5A5_1234);
        next_cycle();
        a_read = 1'b0;
        #2;
        chk("rd_count", a_cnt, 32'd2);
        chk1("rd_after_hiz", a_hiz, 1'b1);

        // Out-of-range read then out-of-range write
        s_snap = a_strobes;
        next_cycle();
        a_read = 1'b1; a_addr = 32'h0004_0000;
        #2;
        chk1("oor_c0_ready", a_rdy, 1'b0);
        next_cycle();
        #2;
        chk1("oor_c1_ready", a_rdy, 1'b1);
        chk("oor_c1_data", a_data, 32'h0000_0000);
        chk1("oor_c1_en", a_en, 1'b0);
        next_cycle();
        a_read = 1'b0;
        #2;
        chk1("oor_err", a_err, 1'b1);
        chk("oor_eaddr", a_eaddr, 32'h0004_0000);
        next_cycle();
        a_write = 1'b1; a_addr = 32'h0005_0000; a_drv = 1'b1; a_drv_val = 32'h0000_5555;
        next_cycle();
        a_drv = 1'b0;
        #2;
        chk1("oorw_c1_ready", a_rdy, 1'b1);
        chk1("oorw_c1_hiz", a_hiz, 1'b1);
        next_cycle();
        a_write = 1'b0;
        #2;
        chk("oorw_eaddr_kept", a_eaddr, 32'h0004_0000);
        chk1("oorw_err", a_err, 1'b1);
        chk("oor_no_strobe", a_strobes, s_snap);
        chk("oor_count", a_cnt, 32'd4);

        // Reset during RDWAIT
        next_cycle();
        a_read = 1'b1; a_addr = 32'h0000_0100;
        next_cycle();
        next_cycle();
        rst = 1'b1; a_read = 1'b0;
        #2;
        chk1("mrst_en", a_en, 1'b0);
        chk1("mrst_ready", a_rdy, 1'b0);
        chk("mrst_count", a_cnt, 32'd0);
        chk1("mrst_err", a_err, 1'b0);
        s_snap = a_strobes;
        next_cycle();
        rst = 1'b0;
        #2;
        chk1("mrst_idle_ready", a_rdy, 1'b1);
        next_cycle();
        #2;
        chk("mrst_no_strobe", a_strobes, s_snap);
        next_cycle();
        a_read = 1'b1; a_addr = 32'h0000_0100;
        next_cycle();
        next_cycle();
        next_cycle();
        #2;
        chk1("mrst_rd_ready", a_rdy, 1'b1);
        chk("mrst_rd_data", a_data, 32'hA5A5_1234);
        next_cycle();
        a_read = 1'b0;
        #2;
        chk("mrst_rd_count", a_cnt, 32'd1);

        // Fetch at 0x0, then a write in the cycle right after DONE
        next_cycle();
        a_read = 1'b1; a_addr = 32'h0000_0000;
        next_cycle();
        next_cycle();
        next_cycle();
        #2;
        chk1("fetch_ready", a_rdy, 1'b1);
        chk("fetch_data", a_data, 32'h0800_0000);
        next_cycle();
        a_read = 1'b0; a_write = 1'b1; a_addr = 32'h0000_0008;
        a_drv = 1'b1; a_drv_val = 32'h1111_2222;
        #2;
        chk1("b2b_c0_ready", a_rdy, 1'b0);
        next_cycle();
        a_drv = 1'b0;
        #2;
        chk1("b2b_c1_ready", a_rdy, 1'b0);
        chk1("b2b_c1_we", a_we, 1'b1);
        chk("b2b_c1_saddr", {16'h0, a_saddr}, 32'h0000_0002);
        next_cycle();
        #2;
        chk1("b2b_c2_ready", a_rdy, 1'b1);
        next_cycle();
        a_write = 1'b0;
        #2;
        chk("b2b_mem", mem0[8'h02], 32'h1111_2222);
        chk("b2b_count", a_cnt, 32'd3);

        // Read and write together: handled as a write, flagged as error
        next_cycle();
        a_read = 1'b1; a_write = 1'b1; a_addr = 32'h0000_000C;
        a_drv = 1'b1; a_drv_val = 32'h3333_4444;
        next_cycle();
        a_drv = 1'b0;
        #2;
        chk1("both_c1_en", a_en, 1'b1);
        chk1("both_c1_we", a_we, 1'b1);
        next_cycle();
        #2;
        chk1("both_c2_ready", a_rdy, 1'b1);
        chk1("both_c2_hiz", a_hiz, 1'b1);
        next_cycle();
        a_read = 1'b0; a_write = 1'b0;
        #2;
        chk1("both_err", a_err, 1'b1);
        chk("both_eaddr", a_eaddr, 32'h0000_000C);
        chk("both_mem", mem0[8'h03], 32'h3333_4444);
        chk("both_count", a_cnt, 32'd4);

        // WAIT_STATES=2, READ_LATENCY=3: read 0x10
        next_cycle();
        b_read = 1'b1; b_addr = 32'h0000_0010;
        for (int c = 0; c < 8; c++) begin
            #2;
            chk1($sformatf("ws_en_c%0d", c), b_en, (c == 3));
            chk1($sformatf("ws_ready_c%0d", c), b_rdy, (c == 7));
            if (c == 7) chk("ws_data", b_data, 32'hCAFE_0004);
            next_cycle();
        end
        b_read = 1'b0;
        #2;
        chk("ws_strobes", b_strobes, 1);
        chk("ws_count", b_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_controller.md
Name: mem_bus_controller

Overview:
- Downstream memory-side partner of the multi-cycle CPU core. Terminates the core's shared 32-bit address/data bus (mem_read, mem_write, mem_ready handshake).
- Converts each bus request into a synchronous single-port SRAM access, with configurable wait states and read latency.
- Generates mem_ready, drives read data back onto the shared bus, and flags out-of-range accesses.

Parameters:
ADDR_BITS, 16, SRAM word-address width; MEM_WORDS = 2^ADDR_BITS; valid byte range 0 .. MEM_WORDS*4-1
WAIT_STATES, 0, extra idle cycles inserted before every in-range SRAM access (0..15)
READ_LATENCY, 1, cycles from sram_en to valid sram_rdata (1..3)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cpu_addr  input  32  byte address from core
cpu_data  inout  32  shared data bus; driven by this block only in DONE of a read, else high-Z
cpu_mem_read  input  1  core read request (level, held until ready)
cpu_mem_write  input  1  core write request (level, held until ready)
cpu_mem_ready  output  1  core advance enable
sram_en  output  1  SRAM access strobe, one cycle per access
sram_we  output  1  SRAM write enable, valid with sram_en
sram_addr  output  ADDR_BITS  SRAM word address
sram_wdata  output  32  SRAM write data
sram_rdata  input  32  SRAM read data, valid READ_LATENCY cycles after sram_en
bus_error  output  1  sticky error flag
error_addr  output  32  cpu_addr of first erroring request
access_count  output  32  completed requests, wraps at 2^32

Behaviour:
- Reset (async, any state): FSM to IDLE.
  - Registered outputs clear immediately: sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0, bus_error=0, error_addr=0, access_count=0.
  - cpu_data=Z; cpu_mem_ready=0 while rst=1.
  - Any in-flight access is abandoned; no SRAM strobe is issued after reset.
- States: IDLE, WAIT, ACCESS, RDWAIT, DONE.
- cpu_mem_ready (combinational) = (IDLE && !cpu_mem_read && !cpu_mem_write) || DONE.
  - The core stalls on every state when ready is low, so ready must be high whenever no request is pending.
- IDLE, request present (cycle 0): latch op, cpu_addr, cpu_data (writes); later changes on the bus are ignored until DONE.
  - Out of range (cpu_addr >= MEM_WORDS*4): go to DONE; no SRAM strobe.
  - Else WAIT_STATES>0: go to WAIT.
  - Else: go to ACCESS.
- Word address = latched cpu_addr[ADDR_BITS+1:2]; cpu_addr[1:0] ignored (not an error).
- WAIT: counts WAIT_STATES cycles, then ACCESS.
- ACCESS (one cycle): sram_en=1, sram_addr=word address.
  - Write: sram_we=1, sram_wdata=latched data, then DONE.
  - Read: sram_we=0, then RDWAIT.
- RDWAIT: held READ_LATENCY cycles; sram_rdata is registered into the read buffer on the last RDWAIT edge; then DONE.
- DONE (one cycle): cpu_mem_ready=1. For reads, cpu_data = read buffer (0x00000000 if out of range). access_count += 1. Next state IDLE.
- Request timing, measured from the cycle the request first appears (cycle 0):
  - In-range write: ready in cycle WAIT_STATES+2.
  - In-range read: ready in cycle WAIT_STATES+READ_LATENCY+2.
  - Out-of-range: ready in cycle 1.
- Back-to-back requests: DONE always returns to IDLE, so a request present in the cycle after DONE is handled as a fresh request; ready is low in that cycle.
- Errors:
  - Out-of-range access: no SRAM write; reads return 0.
  - cpu_mem_read and cpu_mem_write both high in IDLE: treated as a write.
  - Either error sets bus_error. bus_error is sticky until rst. error_addr captures only the first error.
- Request dropped before DONE: the access still completes internally. DONE lasts one cycle and the block returns to IDLE. cpu_data is not driven if cpu_mem_read is low in DONE.
- cpu_data is never driven while cpu_mem_write=1.

Test Plan:
- Idle with rst released, no request for 5 cycles -> cpu_mem_ready=1, sram_en=0, cpu_data=Z, access_count=0.
- Defaults: write 0xA5A5_1234 to 0x0000_0100, then read 0x0000_0100 -> write ready cycle 2, sram_addr=0x0040 with sram_we=1 in cycle 1; read ready cycle 3, cpu_data=0xA5A5_1234; access_count=2.
- WAIT_STATES=2, READ_LATENCY=3, read 0x0000_0010 -> sram_en only in cycle 3; ready in cycle 7; one strobe total.
- Read 0x0004_0000 (ADDR_BITS=16) -> ready in cycle 1, cpu_data=0, no sram_en, bus_error=1, error_addr=0x0004_0000. A later error at 0x0005_0000 leaves error_addr unchanged.
- Assert rst in the RDWAIT cycle of a read -> sram_en=0 and cpu_mem_ready=0 immediately, state IDLE. After release, the next read completes normally with count restarted from 0.
- Fetch at 0x0 with mem_read held, core drops it after ready, then a write appears in the next cycle -> ready low in that cycle; the write completes 2 cycles later; fetch data 0x0800_0000 preloaded is returned on cpu_data.
